sweep_sequencer: RTL and testbench
==================================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter PTS_W, default 10, meaning point-index/count width.
REQ-002 SHALL have parameter SETTLE_CYC, default 1000, meaning clk cycles waited after each frequency update before measurement restart.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2000000, meaning max clk cycles waiting for vpp_found.
REQ-004 SHALL have ports: clk in 1 (100 MHz system clock); rst_n in 1 (reset).
REQ-005 SHALL have ports: start in 1 (begin sweep, pulse); abort in 1 (cancel sweep).
REQ-006 SHALL have ports: kw_start in 32 (first frequency word); kw_step in 32 (per-point increment); kw_offset in 32 (sample-clock offset word); n_points in PTS_W (point count).
REQ-007 SHALL have ports: kw_out out 32 (sweep DDS word); samp_kw_out out 32 (sample-clock DDS word); meas_restart out 1 (Vpp-detector restart pulse).
REQ-008 SHALL have ports: vpp_in in 12 (measured peak-to-peak); vpp_found in 1 (measurement complete, asynchronous to clk).
REQ-009 SHALL have ports: res_valid out 1; res_ready in 1; res_vpp out 12; res_idx out PTS_W (result stream to CPU).
REQ-010 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); timeout_err out 1 (sticky).
REQ-011 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-012 SHALL implement states IDLE, LOAD, SETTLE, MEAS, WAIT_FOUND, PUSH, NEXT, DONE.
REQ-013 IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-014 LOAD: latch kw_start, kw_step, kw_offset and n_points; set idx=0; if n_points=0 go to DONE, else SETTLE.
REQ-015 kw_out SHALL update in LOAD/NEXT; samp_kw_out = kw_out + kw_offset mod 2^32, registered.
REQ-016 SETTLE: count SETTLE_CYC cycles, then MEAS.
REQ-017 MEAS: assert meas_restart for exactly one cycle, then WAIT_FOUND.
REQ-018 vpp_found SHALL pass a 2-FF synchronizer plus rising-edge detect; the edge is seen 3 clk after the input rises.
REQ-019 WAIT_FOUND: on edge, capture vpp_in into res_vpp and go to PUSH.
REQ-020 PUSH: res_valid=1 with res_vpp/res_idx stable until res_ready=1.
REQ-021 On the handshake, drop res_valid the next cycle and go to NEXT.
REQ-022 NEXT: if idx=n_points-1 go to DONE; else idx+1, kw_out+=kw_step mod 2^32 (wrap, no saturation), SETTLE.
REQ-023 DONE: pulse done one cycle, then IDLE; kw_out holds last word.
REQ-024 abort=1 in any state SHALL force IDLE next cycle with res_valid=0 and no done pulse.
REQ-025 abort and start together SHALL leave the block in IDLE (abort wins).
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 A vpp_found edge outside WAIT_FOUND SHALL be discarded.

Reset
REQ-028 rst_n=0 SHALL put the FSM in IDLE and clear these outputs to 0: kw_out, samp_kw_out, meas_restart, res_valid, res_vpp, res_idx, busy, done, timeout_err.
REQ-029 rst_n=0 SHALL clear all counters and synchronizer flops.
REQ-030 Reset mid-sweep SHALL override all other inputs.

Configuration
REQ-031 With SWEEP_TIMEOUT_EN defined, WAIT_FOUND SHALL count TIMEOUT_CYC cycles.
REQ-032 On expiry the block SHALL set res_vpp=12'h000 and timeout_err=1, then go to PUSH.
REQ-033 timeout_err SHALL be cleared only by LOAD or reset.
REQ-034 Without SWEEP_TIMEOUT_EN, WAIT_FOUND SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-035 Package sweep_pkg SHALL hold: the state enum, KW_W=32, VPP_W=12.
REQ-036 Sub-module vpp_found_sync SHALL contain the 2-FF synchronizer plus edge detect.

Verification
REQ-037 kw_start=1000, kw_step=500, n_points=4, res_ready=1, vpp_found raised 50 cycles after each meas_restart -> kw_out 1000/1500/2000/2500; res_idx 0..3; done once.
REQ-038 kw_start=32'hFFFF_FF00, kw_step=32'h200, n_points=2 -> kw_out 32'hFFFF_FF00 then 32'h0000_0100.
REQ-039 res_ready held 0 for 20 cycles in PUSH -> res_valid and res_vpp stable for those cycles; no new meas_restart until the handshake.
REQ-040 n_points=0 -> done pulse 2 cycles after start; res_valid never asserted.
REQ-041 abort in SETTLE of point 2 -> IDLE next cycle, busy=0, no done; a new start works normally.
REQ-042 With SWEEP_TIMEOUT_EN and vpp_found never rising -> res_vpp=0 and timeout_err=1 after TIMEOUT_CYC; sweep continues.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared widths and FSM state encoding for the frequency-sweep sequencer.
package sweep_pkg;

  localparam int KW_W  = 32;
  localparam int VPP_W = 12;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SETTLE     = 3'd2,
    MEAS       = 3'd3,
    WAIT_FOUND = 3'd4,
    PUSH       = 3'd5,
    NEXT       = 3'd6,
    DONE       = 3'd7
  } state_e;

endpackage

// File: rtl/vpp_found_sync.sv
// Two-flop synchronizer for the asynchronous vpp_found flag plus a rising-edge detector.
// The edge pulse is valid two clocks after the input rises and is acted upon at the third edge.
module vpp_found_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  // [0] and [1] form the synchronizer; [2] is the previous synchronized value.
  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], async_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-sweep sequencer: steps a DDS word across n_points, waits for a Vpp measurement at
// each point and streams (idx, vpp) results to the CPU. Define SWEEP_TIMEOUT_EN to add a
// WAIT_FOUND timeout that pushes a zero result and sets the sticky timeout_err flag.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int PTS_W       = 10,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [KW_W-1:0]     kw_start,
  input  logic [KW_W-1:0]     kw_step,
  input  logic [KW_W-1:0]     kw_offset,
  input  logic [PTS_W-1:0]    n_points,
  output logic [KW_W-1:0]     kw_out,
  output logic [KW_W-1:0]     samp_kw_out,
  output logic                meas_restart,
  input  logic [VPP_W-1:0]    vpp_in,
  input  logic                vpp_found,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [VPP_W-1:0]    res_vpp,
  output logic [PTS_W-1:0]    res_idx,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

`ifdef SWEEP_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  // Terminal counts; a zero-length setting behaves like a single cycle.
  localparam logic [31:0] SETTLE_LAST  = (SETTLE_CYC  > 0) ? 32'(SETTLE_CYC - 1)  : 32'd0;
  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  state_e             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [PTS_W-1:0]   idx_q, idx_d;
  logic [PTS_W-1:0]   npts_q, npts_d;
  logic [KW_W-1:0]    step_q, step_d;
  logic [KW_W-1:0]    off_q, off_d;
  logic [KW_W-1:0]    kw_q, kw_d;
  logic [KW_W-1:0]    samp_q, samp_d;
  logic [VPP_W-1:0]   vpp_q, vpp_d;
  logic               terr_q, terr_d;
  logic               found_rise;

  vpp_found_sync u_found_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (vpp_found),
    .rise_o  (found_rise)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    npts_d  = npts_q;
    step_d  = step_q;
    off_d   = off_q;
    kw_d    = kw_q;
    vpp_d   = vpp_q;
    terr_d  = terr_q;

    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        npts_d  = n_points;
        step_d  = kw_step;
        off_d   = kw_offset;
        kw_d    = kw_start;
        idx_d   = '0;
        terr_d  = 1'b0;
        state_d = (n_points == '0) ? DONE : SETTLE;
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) state_d = MEAS;
        else                      cnt_d   = cnt_q + 32'd1;
      end
      MEAS: state_d = WAIT_FOUND;
      WAIT_FOUND: begin
        // Edges arriving in any other state fall through here unobserved and are lost.
        if (found_rise) begin
          vpp_d   = vpp_in;
          state_d = PUSH;
        end else if (TIMEOUT_EN && cnt_q >= TIMEOUT_LAST) begin
          vpp_d   = '0;
          terr_d  = 1'b1;
          state_d = PUSH;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      PUSH: if (res_ready) state_d = NEXT;
      NEXT: begin
        if (idx_q == npts_q - PTS_W'(1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + PTS_W'(1);
          kw_d    = kw_q + step_q;
          state_d = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort beats every transition, including a simultaneous start.
    if (abort) state_d = IDLE;
  end

  // The sample-clock word tracks the next sweep word so both DDS words change on the same edge.
  assign samp_d = kw_d + off_d;

  // NOTE: synchronous reset clears every flop here; there is no memory array that would need to stay unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      npts_q  <= '0;
      step_q  <= '0;
      off_q   <= '0;
      kw_q    <= '0;
      samp_q  <= '0;
      vpp_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      npts_q  <= npts_d;
      step_q  <= step_d;
      off_q   <= off_d;
      kw_q    <= kw_d;
      samp_q  <= samp_d;
      vpp_q   <= vpp_d;
      terr_q  <= terr_d;
    end
  end

  assign kw_out       = kw_q;
  assign samp_kw_out  = samp_q;
  assign res_vpp      = vpp_q;
  assign res_idx      = idx_q;
  assign timeout_err  = terr_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign meas_restart = (state_q == MEAS);
  assign res_valid    = (state_q == PUSH);

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: directed sweeps push expected results, a monitor pops
// them at each result handshake, and a responder models the Vpp detector.
`timescale 1ns/1ps
module tb_sweep_sequencer;

  localparam int PTS_W = 10;
  localparam int SETTLE = 8;
  localparam int TMO = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [31:0]       kw_start = '0;
  logic [31:0]       kw_step = '0;
  logic [31:0]       kw_offset = '0;
  logic [PTS_W-1:0]  n_points = '0;
  logic [31:0]       kw_out;
  logic [31:0]       samp_kw_out;
  logic              meas_restart;
  logic [11:0]       vpp_in = '0;
  logic              vpp_found = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [11:0]       res_vpp;
  logic [PTS_W-1:0]  res_idx;
  logic              busy;
  logic              done;
  logic              timeout_err;

  sweep_sequencer #(
    .PTS_W       (PTS_W),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .kw_start     (kw_start),
    .kw_step      (kw_step),
    .kw_offset    (kw_offset),
    .n_points     (n_points),
    .kw_out       (kw_out),
    .samp_kw_out  (samp_kw_out),
    .meas_restart (meas_restart),
    .vpp_in       (vpp_in),
    .vpp_found    (vpp_found),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_vpp      (res_vpp),
    .res_idx      (res_idx),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PTS_W-1:0] idx;
    logic [11:0]      vpp;
    logic [31:0]      kw;
    logic [31:0]      samp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  int          n_done = 0;
  int          exp_done = 0;
  logic        resp_en = 1'b1;
  logic [11:0] vpp_base = 12'h100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [PTS_W-1:0] idx, input logic [11:0] vpp,
                          input logic [31:0] kw, input logic [31:0] samp);
    exp_t e;
    e.idx = idx; e.vpp = vpp; e.kw = kw; e.samp = samp;
    exp_q.push_back(e);
  endtask

  task automatic start_sweep(input logic [31:0] ks, input logic [31:0] st,
                             input logic [31:0] off, input logic [PTS_W-1:0] n);
    kw_start = ks; kw_step = st; kw_offset = off; n_points = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'd0, busy}, 32'd0);
    step();
  endtask

  // Vpp detector model: 50 cycles after each restart pulse, present vpp_base + 3*k and raise found.
  initial begin : responder
    int k = 0;
    forever begin
      @(negedge clk);
      if (start) k = 0;
      if (meas_restart && resp_en) begin
        repeat (50) @(posedge clk);
        #1;
        vpp_in = vpp_base + 12'(3 * k);
        k++;
        vpp_found = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vpp_found = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: idx %0d vpp %0h, nothing expected", res_idx, res_vpp);
        end else begin
          e = exp_q.pop_front();
          check("res_idx", 32'(res_idx), 32'(e.idx));
          check("res_vpp", 32'(res_vpp), 32'(e.vpp));
          check("kw_out", kw_out, e.kw);
          check("samp_kw_out", samp_kw_out, e.samp);
        end
        n_pop++;
      end
    end
  end

  initial begin : stimulus
    int i;
    int p0;

    // Reset with start asserted: reset must win and clear every output.
    start = 1'b1;
    repeat (3) step();
    check("rst_kw_out", kw_out, 32'd0);
    check("rst_samp_kw_out", samp_kw_out, 32'd0);
    check("rst_meas_restart", {31'd0, meas_restart}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_vpp", 32'(res_vpp), 32'd0);
    check("rst_res_idx", 32'(res_idx), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step();

    // Four-point sweep, always ready.
    vpp_base = 12'h100;
    push_exp(0, 12'h100, 32'd1000, 32'd1100);
    push_exp(1, 12'h103, 32'd1500, 32'd1600);
    push_exp(2, 12'h106, 32'd2000, 32'd2100);
    push_exp(3, 12'h109, 32'd2500, 32'd2600);
    start_sweep(32'd1000, 32'd500, 32'd100, 4);
    wait_idle("t1_finish", 2000);
    exp_done++;
    check("t1_done_count", 32'(n_done), 32'(exp_done));
    check("t1_kw_hold", kw_out, 32'd2500);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Word wraps modulo 2^32.
    vpp_base = 12'h200;
    push_exp(0, 12'h200, 32'hFFFF_FF00, 32'hFFFF_FF10);
    push_exp(1, 12'h203, 32'h0000_0100, 32'h0000_0110);
    start_sweep(32'hFFFF_FF00, 32'h200, 32'h10, 2);
    wait_idle("t2_finish", 1000);
    exp_done++;
    check("t2_done_count", 32'(n_done), 32'(exp_done));

    // Back-pressure: result must hold and no new measurement may start.
    res_ready = 1'b0;
    vpp_base = 12'h300;
    push_exp(0, 12'h300, 32'h1234, 32'h1235);
    start_sweep(32'h1234, 32'd1, 32'd1, 1);
    i = 0;
    while (!res_valid && i < 300) begin
      @(negedge clk);
      i++;
    end
    check("t3_valid_seen", {31'd0, res_valid}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, res_valid}, 32'd1);
      check("t3_hold_vpp", 32'(res_vpp), 32'h300);
      check("t3_no_restart", {31'd0, meas_restart}, 32'd0);
    end
    step();
    res_ready = 1'b1;
    wait_idle("t3_finish", 200);
    exp_done++;
    check("t3_done_count", 32'(n_done), 32'(exp_done));

    // Zero points: done two cycles after start, no result.
    start_sweep(32'd77, 32'd1, 32'd0, 0);
    @(negedge clk);
    check("t4_load_busy", {31'd0, busy}, 32'd1);
    check("t4_load_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t4_done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("t4_done_low", {31'd0, done}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    step();
    exp_done++;
    check("t4_done_count", 32'(n_done), 32'(exp_done));

    // Abort in SETTLE of the second point.
    vpp_base = 12'h400;
    push_exp(0, 12'h400, 32'd5000, 32'd5000);
    p0 = n_pop;
    start_sweep(32'd5000, 32'd10, 32'd0, 4);
    i = 0;
    while (n_pop == p0 && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("t5_first_result", 32'(n_pop), 32'(p0 + 1));
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", {31'd0, busy}, 32'd0);
    check("t5_abort_done", {31'd0, done}, 32'd0);
    check("t5_abort_valid", {31'd0, res_valid}, 32'd0);
    repeat (80) step();
    check("t5_no_done", 32'(n_done), 32'(exp_done));

    // Abort together with start stays idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("t5_abort_start_idle", {31'd0, busy}, 32'd0);
    step();

    // Restart after abort works normally.
    vpp_base = 12'h500;
    push_exp(0, 12'h500, 32'd10, 32'd20);
    push_exp(1, 12'h503, 32'd13, 32'd23);
    start_sweep(32'd10, 32'd3, 32'd10, 2);
    wait_idle("t5_restart_finish", 1000);
    exp_done++;
    check("t5_restart_done_count", 32'(n_done), 32'(exp_done));

`ifdef SWEEP_TIMEOUT_EN
    // Detector never answers: each point times out with a zero result.
    resp_en = 1'b0;
    push_exp(0, 12'h000, 32'd100, 32'd100);
    push_exp(1, 12'h000, 32'd200, 32'd200);
    start_sweep(32'd100, 32'd100, 32'd0, 2);
    wait_idle("t6_finish", 2000);
    exp_done++;
    check("t6_timeout_err_set", {31'd0, timeout_err}, 32'd1);
    resp_en = 1'b1;
    vpp_base = 12'h600;
    push_exp(0, 12'h600, 32'd7, 32'd7);
    start_sweep(32'd7, 32'd0, 32'd0, 1);
    step();
    check("t6_timeout_err_cleared", {31'd0, timeout_err}, 32'd0);
    wait_idle("t6_clean_finish", 1000);
    exp_done++;
`else
    check("t6_timeout_err_tied", {31'd0, timeout_err}, 32'd0);
`endif
    check("t6_done_count", 32'(n_done), 32'(exp_done));

    // Reset mid-sweep overrides a held start.
    start_sweep(32'hABCD, 32'd1, 32'd1, 3);
    repeat (4) step();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    @(negedge clk);
    check("t7_rst_busy", {31'd0, busy}, 32'd0);
    check("t7_rst_kw_out", kw_out, 32'd0);
    check("t7_rst_samp", samp_kw_out, 32'd0);
    check("t7_rst_valid", {31'd0, res_valid}, 32'd0);
    check("t7_rst_idx", 32'(res_idx), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (20) step();
    check("t7_busy_after", {31'd0, busy}, 32'd0);
    check("t7_done_count", 32'(n_done), 32'(exp_done));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
